// File: rtl/gpio_bus_arb_pkg.sv
// Shared types and default bus widths for the GPIO core bus arbiter.
package gpio_bus_arb_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/gpio_bus_arb_if.sv
// Requester-side and GPIO-core-side signals of the arbiter.
// slave: the arbiter's view; master: the requesters plus GPIO core around it.
interface gpio_bus_arb_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned AW    = gpio_bus_arb_pkg::AW_DEF,
  parameter int unsigned DW    = gpio_bus_arb_pkg::DW_DEF
) ();

  logic [N_REQ-1:0]    s_req;
  logic [N_REQ-1:0]    s_we;
  logic [N_REQ*AW-1:0] s_addr;
  logic [N_REQ*DW-1:0] s_wd;
  logic [N_REQ-1:0]    s_ack;
  logic [DW-1:0]       s_rd;
  logic [AW-1:0]       m_addr;
  logic                m_we;
  logic [DW-1:0]       m_wd;
  logic [DW-1:0]       m_rd;
  logic                busy;

  modport slave (
    input  s_req, s_we, s_addr, s_wd, m_rd,
    output s_ack, s_rd, m_addr, m_we, m_wd, busy
  );

  modport master (
    output s_req, s_we, s_addr, s_wd, m_rd,
    input  s_ack, s_rd, m_addr, m_we, m_wd, busy
  );

endinterface

// File: rtl/gpio_bus_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % int'(N_REQ);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_bus_arb.sv
// Round-robin arbiter sharing one GPIO core register bus among N_REQ requesters.
// Each transfer is IDLE (grant) -> XFER (core access) -> RESP (ack).
module gpio_bus_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned AW    = gpio_bus_arb_pkg::AW_DEF,
  parameter int unsigned DW    = gpio_bus_arb_pkg::DW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  gpio_bus_arb_if.slave  bus
);

  import gpio_bus_arb_pkg::*;

  localparam int unsigned IW = $clog2(N_REQ);

  state_e           state;
  logic [IW-1:0]    ptr;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] ack_q;
  logic [DW-1:0]    rd_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wd_q;
  logic             we_q;
  logic             busy_q;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_vld;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wd;
  logic [IW-1:0]    ptr_nxt;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req   (bus.s_req),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .valid (gnt_vld)
  );

  // Mux the winning requester's payload out of the packed vectors.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_wd   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt[i]) begin
        sel_we   = bus.s_we[i];
        sel_addr = bus.s_addr[i*AW +: AW];
        sel_wd   = bus.s_wd[i*DW +: DW];
      end
    end
  end

  assign ptr_nxt = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      win_oh <= '0;
      ack_q  <= '0;
      rd_q   <= '0;
      addr_q <= '0;
      wd_q   <= '0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            state  <= XFER;
            busy_q <= 1'b1;
            win_oh <= gnt;
            we_q   <= sel_we;
            addr_q <= sel_addr;
            wd_q   <= sel_wd;
            ptr    <= ptr_nxt;
          end
        end
        XFER: begin
          // Read data is captured even on writes, giving pre-write contents.
          state <= RESP;
          we_q  <= 1'b0;
          rd_q  <= bus.m_rd;
          ack_q <= win_oh;
        end
        RESP: begin
          state  <= IDLE;
          ack_q  <= '0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          ack_q  <= '0;
          we_q   <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ack  = ack_q;
  assign bus.s_rd   = rd_q;
  assign bus.m_addr = addr_q;
  assign bus.m_we   = we_q;
  assign bus.m_wd   = wd_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Randomized bench for gpio_bus_arb against a transaction-level round-robin model.
module tb_gpio_bus_arb;

  import gpio_bus_arb_pkg::*;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned AW    = AW_DEF;
  localparam int unsigned DW    = DW_DEF;
  localparam int unsigned DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpio_bus_arb_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

  gpio_bus_arb #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // GPIO core stand-in: registers read combinationally, written on m_we.
  logic [DW-1:0] core     [DEPTH];
  logic [DW-1:0] seed_mem [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];
  logic          core_load;

  assign bus.m_rd = core[bus.m_addr];

  always @(posedge clk) begin
    if (core_load) begin
      for (int i = 0; i < int'(DEPTH); i++) core[i] <= seed_mem[i];
    end else if (bus.m_we) begin
      core[bus.m_addr] <= bus.m_wd;
    end
  end

  // Reference state: requester payloads, arbitration pointer, served order.
  logic          we_v   [N_REQ];
  logic [AW-1:0] addr_v [N_REQ];
  logic [DW-1:0] wd_v   [N_REQ];
  int            ref_ptr;
  int            order_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic int ref_pick(input logic [N_REQ-1:0] m, input int p);
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (m[(p + k) % int'(N_REQ)]) return (p + k) % int'(N_REQ);
    end
    return 0;
  endfunction

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we_v[i]   = we;
    addr_v[i] = a;
    wd_v[i]   = d;
    bus.s_we[i]            = we;
    bus.s_addr[i*AW +: AW] = a;
    bus.s_wd[i*DW +: DW]   = d;
    bus.s_req[i]           = 1'b1;
  endtask

  // Called at a negedge in IDLE with requests applied; serves them all.
  task automatic serve_all(input logic [N_REQ-1:0] force_drop);
    logic [N_REQ-1:0] pend;
    logic [DW-1:0]    exp_rd;
    int               w;
    pend = bus.s_req;
    order_q.delete();
    while (pend != '0) begin
      w = ref_pick(pend, ref_ptr);
      check("idle_busy", 64'(bus.busy), 64'(0));
      @(negedge clk);
      check("xfer_we",   64'(bus.m_we), 64'(we_v[w]));
      check("xfer_addr", 64'(bus.m_addr), 64'(addr_v[w]));
      check("xfer_wd",   64'(bus.m_wd), 64'(wd_v[w]));
      check("xfer_busy", 64'(bus.busy), 64'(1));
      check("xfer_ack",  64'(bus.s_ack), 64'(0));
      exp_rd = ref_mem[addr_v[w]];
      if (force_drop[w] || $urandom_range(0, 3) == 0) bus.s_req[w] = 1'b0;
      @(negedge clk);
      check("resp_ack",  64'(bus.s_ack), 64'(1) << w);
      check("resp_rd",   64'(bus.s_rd), 64'(exp_rd));
      check("resp_we",   64'(bus.m_we), 64'(0));
      if (we_v[w]) ref_mem[addr_v[w]] = wd_v[w];
      bus.s_req[w] = 1'b0;
      pend[w]      = 1'b0;
      ref_ptr      = (w + 1) % int'(N_REQ);
      order_q.push_back(w);
      @(negedge clk);
    end
    check("idle_ack", 64'(bus.s_ack), 64'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    bus.s_req = '0;
    @(negedge clk);
    rst = 1'b0;
    ref_ptr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    core_load = 1'b1;
    bus.s_req = '0;
    bus.s_we  = '0;
    bus.s_addr = '0;
    bus.s_wd  = '0;
    ref_ptr   = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      seed_mem[i] = $urandom;
      ref_mem[i]  = seed_mem[i];
    end
    seed_mem[8] = 32'h0000_00C3;
    ref_mem[8]  = 32'h0000_00C3;
    for (int i = 0; i < int'(N_REQ); i++) begin
      we_v[i] = 1'b0; addr_v[i] = '0; wd_v[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    core_load = 1'b0;
    check("rst_ack",  64'(bus.s_ack), 64'(0));
    check("rst_rd",   64'(bus.s_rd), 64'(0));
    check("rst_we",   64'(bus.m_we), 64'(0));
    check("rst_addr", 64'(bus.m_addr), 64'(0));
    check("rst_wd",   64'(bus.m_wd), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // No requests: must stay idle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_stay_busy", 64'(bus.busy), 64'(0));
      check("idle_stay_we", 64'(bus.m_we), 64'(0));
    end

    // Single write from requester 1.
    set_req(1, 1'b1, AW'(5'h04), 32'h0000_00A5);
    serve_all('0);

    // Single read from requester 2 of a known register.
    set_req(2, 1'b0, AW'(5'h08), 32'h0);
    serve_all('0);
    check("read_c3", 64'(bus.s_rd), 64'(32'h0000_00C3));

    // All four from reset, twice: order 0..3 each time.
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < int'(N_REQ); i++)
        set_req(i, 1'(($urandom_range(0, 1))), AW'($urandom), $urandom);
      serve_all('0);
      for (int i = 0; i < int'(N_REQ); i++) check("order_all", 64'(order_q[i]), 64'(i));
    end

    // Wrap: grant 2 leaves ptr at 3, so 3 is served before 0.
    set_req(2, 1'b0, AW'(1), 32'h0);
    serve_all('0);
    set_req(0, 1'b1, AW'(3), 32'h1111_0000);
    set_req(3, 1'b1, AW'(6), 32'h3333_0000);
    serve_all('0);
    check("wrap_first", 64'(order_q[0]), 64'(3));
    check("wrap_second", 64'(order_q[1]), 64'(0));

    // Early drop of requester 0 during XFER still gets its ack.
    set_req(0, 1'b0, AW'(6), 32'h0);
    serve_all(4'b0001);

    // Reset during RESP aborts the ack and resets the pointer.
    set_req(2, 1'b1, AW'(9), 32'hDEAD_BEEF);
    @(negedge clk);
    check("abort_xfer_we", 64'(bus.m_we), 64'(1));
    @(negedge clk);
    check("abort_pre_ack", 64'(bus.s_ack), 64'(4'b0100));
    ref_mem[9] = 32'hDEAD_BEEF;
    rst = 1'b1;
    bus.s_req = '0;
    #1;
    check("abort_ack", 64'(bus.s_ack), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_we", 64'(bus.m_we), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    ref_ptr = 0;
    @(negedge clk);
    check("post_abort_ack", 64'(bus.s_ack), 64'(0));
    set_req(0, 1'b0, AW'(9), 32'h0);
    set_req(3, 1'b0, AW'(9), 32'h0);
    serve_all('0);
    check("post_rst_first", 64'(order_q[0]), 64'(0));

    // Random rounds.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if ($urandom_range(0, 1) == 1)
          set_req(i, 1'(($urandom_range(0, 1))), AW'($urandom), $urandom);
      end
      serve_all('0);
      for (int c = 0; c < int'($urandom_range(0, 2)); c++) begin
        @(negedge clk);
        check("rand_idle_busy", 64'(bus.busy), 64'(0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gpio_bus_arb.md
GPIO_BUS_ARB -- requirements
Module: gpio_bus_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (legal range 2..8).
REQ-002 SHALL have parameter AW, default 5, register address width of the GPIO core bus.
REQ-003 SHALL have parameter DW, default 32, data width of the GPIO core bus.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port s_req  input  N_REQ  per-requester transfer request, held until ack.
REQ-007 SHALL have port s_we  input  N_REQ  per-requester write (1) / read (0).
REQ-008 SHALL have port s_addr  input  N_REQ*AW  packed addresses; requester i uses slice [i*AW +: AW].
REQ-009 SHALL have port s_wd  input  N_REQ*DW  packed write data; requester i uses slice [i*DW +: DW].
REQ-010 SHALL have port s_ack  output  N_REQ  one-hot, one-cycle completion pulse.
REQ-011 SHALL have port s_rd  output  DW  read data, valid in the s_ack cycle, shared by all requesters.
REQ-012 SHALL have port m_addr  output  AW  address to the GPIO core.
REQ-013 SHALL have port m_we  output  1  write enable to the GPIO core.
REQ-014 SHALL have port m_wd  output  DW  write data to the GPIO core.
REQ-015 SHALL have port m_rd  input  DW  read data from the GPIO core, combinational on m_addr.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, XFER, RESP; one transfer SHALL take exactly 3 cycles (IDLE->XFER->RESP->IDLE).
REQ-018 IDLE: if any s_req bit is set, SHALL select a winner round-robin, latch its s_we/s_addr/s_wd and winner index, and go to XFER; otherwise SHALL stay in IDLE.
REQ-019 Round-robin: search SHALL start at pointer ptr and wrap from N_REQ-1 to 0; after a grant, ptr SHALL become winner+1 modulo N_REQ.
REQ-020 XFER: m_addr/m_wd SHALL drive latched values, m_we SHALL equal the latched we for exactly this one cycle, m_rd SHALL be captured into the read register; next state SHALL be RESP.
REQ-021 Outside XFER, m_we SHALL be 0; m_addr/m_wd SHALL hold their last latched values.
REQ-022 RESP: s_ack[winner] SHALL be 1 and all other s_ack bits 0, s_rd SHALL show the captured data; next state SHALL be IDLE.
REQ-023 On a write, s_rd SHALL still return the m_rd value captured in XFER (pre-write register contents).
REQ-024 s_req changes after latching (XFER/RESP) SHALL NOT affect the transfer in flight; a requester dropping s_req early SHALL still receive s_ack.
REQ-025 Requesters SHALL deassert s_req in the cycle after s_ack; a request still high in that IDLE cycle SHALL be treated as a new transfer.
REQ-026 Simultaneous requests SHALL be served one per 3 cycles in round-robin order; no requester SHALL wait more than 3*(N_REQ-1) cycles after its s_req is sampled in IDLE.

Reset
REQ-027 While rst is high: state=IDLE, ptr=0, s_ack=0, s_rd=0, m_we=0, m_addr=0, m_wd=0, busy=0.
REQ-028 Reset during XFER or RESP SHALL abort the transfer with no s_ack; a write in XFER when rst asserts SHALL NOT be repeated afterwards.

Structure
REQ-029 Package gpio_bus_arb_pkg SHALL hold the FSM state enum and default AW/DW constants.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (inputs req vector and ptr; outputs one-hot grant, index, valid), combinational.

Verification
REQ-031 Single write: s_req[1]=1, we=1, addr=0x04, wd=0xA5 -> m_we=1 with m_addr=0x04, m_wd=0xA5 one cycle after request sampled; s_ack=4'b0010 on the next cycle.
REQ-032 Single read: m_rd tied 0x0000_00C3 for addr=0x08, s_req[2] read -> s_rd=0xC3 with s_ack[2] at cycle 3.
REQ-033 All four requesting from reset -> ack order 0,1,2,3, acks exactly 3 cycles apart; re-request all -> order 0,1,2,3 again.
REQ-034 Wrap: ptr=3 after granting 2, requests on 0 and 3 -> 3 served before 0.
REQ-035 Early drop: s_req[0] low during XFER -> s_ack[0] still pulses in RESP.
REQ-036 rst pulse during RESP -> no s_ack, busy=0, next grant starts search at requester 0.
